// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_capture: measures high time and period of a PWM line on a divided    |
// | tick and flags stuck lines. Optional duty divider: PWM_CAPTURE_DUTY_PCT_EN|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pwm_capture #(
  parameter int CLK_DIV       = 500,
  parameter int CNT_W         = 20,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic [6:0]       duty_pct,
  output logic             duty_valid
);

  localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             sync1, s, prev;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick, rise, fall, timeout;
  logic [CNT_W-1:0] run_cnt, hi_lat;
  logic             publish, expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      prev    <= 1'b0;
      pre_cnt <= '0;
    end else begin
      sync1   <= pwm_in;
      s       <= sync1;
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) prev <= s;
    end
  end

  assign tick    = (pre_cnt == PRE_LAST);
  assign rise    = tick &  s & ~prev;
  assign fall    = tick & ~s &  prev;
  // run_cnt saturates, so the timeout condition is met exactly once per episode.
  assign timeout = tick & ~rise & (run_cnt == TMO_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      hi_lat  <= '0;
    end else if (tick) begin
      if (rise)
        run_cnt <= CNT_W'(1);
      else if (run_cnt != TMO)
        run_cnt <= run_cnt + CNT_W'(1);
      if (fall) hi_lat <= run_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    expire   = 1'b0;
    if (timeout) begin
      expire   = 1'b1;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_nx = HIGH;
        HIGH:    if (fall) state_nx = LOW;
        LOW:     if (rise) begin
                   publish  = 1'b1;
                   state_nx = HIGH;
                 end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_ticks   <= '0;
      period_ticks <= '0;
      meas_valid   <= 1'b0;
      stuck_high   <= 1'b0;
      stuck_low    <= 1'b0;
    end else begin
      meas_valid <= publish | expire;
      if (publish) begin
        period_ticks <= run_cnt;
        high_ticks   <= hi_lat;
      end else if (expire) begin
        period_ticks <= '0;
        high_ticks   <= '0;
        if (s) stuck_high <= 1'b1;
        else   stuck_low  <= 1'b1;
      end
      if (rise) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_PCT_EN
  localparam int DVD_W  = CNT_W + 7;
  localparam int STEP_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]  dvd;
  logic [CNT_W-1:0]  rem, dvsr, diff;
  logic [CNT_W:0]    trial;
  logic [STEP_W-1:0] steps;
  logic              q_bit;

  // Restoring division: dividend bits leave dvd at the top, quotient bits enter at the bottom.
  always_comb begin
    trial = {rem, dvd[DVD_W-1]};
    q_bit = (trial >= {1'b0, dvsr});
    diff  = trial[CNT_W-1:0] - dvsr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      steps      <= '0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_valid) begin
        if (period_ticks != '0) begin
          dvd   <= {7'd0, high_ticks} * DVD_W'(100);
          dvsr  <= period_ticks;
          rem   <= '0;
          steps <= STEP_W'(DVD_W);
        end else begin
          steps      <= '0;
          duty_pct   <= stuck_high ? 7'd100 : 7'd0;
          duty_valid <= 1'b1;
        end
      end else if (steps != '0) begin
        rem   <= q_bit ? diff : trial[CNT_W-1:0];
        dvd   <= {dvd[DVD_W-2:0], q_bit};
        steps <= steps - STEP_W'(1);
        if (steps == STEP_W'(1)) begin
          duty_pct   <= {dvd[5:0], q_bit};
          duty_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign duty_pct   = 7'd0;
  assign duty_valid = 1'b0;
`endif

endmodule
`default_nettype wire
